// File: rtl/ram_loader_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the byte-serial RAM loader.
package ram_loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] ACK_CODE = 8'h06;
  localparam logic [7:0] NAK_CODE = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_WR_DATA,
    ST_WR_STB,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_RD_SEND,
    ST_ACK
  } state_t;

  function automatic logic is_known_opcode(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/ram_loader.sv
// Host-link frame decoder that writes or reads RAM one byte at a time:
// opcode, 4 address bytes, 2 length bytes (LSB first), then payload for WRITE.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            ram_rw_sel_o,
  output logic [XLEN-1:0] ram_rw_addr_o,
  output logic [XLEN-1:0] ram_wr_data_o,
  output logic [3:0]      ram_wr_byte_en_o,
  input  logic [7:0]      ram_rd_data_i,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] ADDR_ONE = XLEN'(1);

  state_t          state;
  state_t          next_state;
  logic [1:0]      byte_idx;
  logic [XLEN-1:0] addr;
  logic [15:0]     len;
  logic            is_write;
  logic [7:0]      wr_byte;
  logic [7:0]      tx_data;
  logic            ram_sel;
  logic            rx_ready_int;
  logic            load_ack;
  logic [7:0]      ack_byte;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A handshake is implied by rx_valid_i in the states that accept bytes.
  always_comb begin
    next_state       = state;
    rx_ready_int     = 1'b0;
    tx_valid_o       = 1'b0;
    ram_wr_byte_en_o = 4'b0000;
    load_ack         = 1'b0;
    ack_byte         = ACK_CODE;
    case (state)
      ST_IDLE: begin
        rx_ready_int = 1'b1;
        if (rx_valid_i) begin
          if (is_known_opcode(rx_data_i)) begin
            next_state = ST_ADDR;
          end else begin
            next_state = ST_ACK;
            load_ack   = 1'b1;
            ack_byte   = NAK_CODE;
          end
        end
      end
      ST_ADDR: begin
        rx_ready_int = 1'b1;
        if (rx_valid_i && byte_idx == 2'd3) next_state = ST_LEN;
      end
      ST_LEN: begin
        rx_ready_int = 1'b1;
        if (rx_valid_i && byte_idx == 2'd1) begin
          if ({rx_data_i, len[7:0]} == 16'd0) begin
            next_state = ST_ACK;
            load_ack   = 1'b1;
          end else if (is_write) begin
            next_state = ST_WR_DATA;
          end else begin
            next_state = ST_RD_ADDR;
          end
        end
      end
      ST_WR_DATA: begin
        rx_ready_int = 1'b1;
        if (rx_valid_i) next_state = ST_WR_STB;
      end
      ST_WR_STB: begin
        ram_wr_byte_en_o = 4'b0001;
        if (len == 16'd1) begin
          next_state = ST_ACK;
          load_ack   = 1'b1;
        end else begin
          next_state = ST_WR_DATA;
        end
      end
      ST_RD_ADDR: next_state = ST_RD_CAP;
      ST_RD_CAP:  next_state = ST_RD_SEND;
      ST_RD_SEND: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) next_state = (len == 16'd1) ? ST_IDLE : ST_RD_ADDR;
      end
      ST_ACK: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // tx_data only moves on RD_CAP or when entering ACK, so it is stable while tx_valid_o waits.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      byte_idx <= 2'd0;
      addr     <= '0;
      len      <= 16'd0;
      is_write <= 1'b0;
      wr_byte  <= 8'h00;
      tx_data  <= 8'h00;
      ram_sel  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid_i) begin
            byte_idx <= 2'd0;
            addr     <= '0;
            len      <= 16'd0;
            is_write <= (rx_data_i == OP_WRITE);
            ram_sel  <= is_known_opcode(rx_data_i);
          end
        end
        ST_ADDR: begin
          if (rx_valid_i) begin
            addr[{byte_idx, 3'b000} +: 8] <= rx_data_i;
            byte_idx <= byte_idx + 2'd1;
          end
        end
        ST_LEN: begin
          if (rx_valid_i) begin
            if (byte_idx == 2'd0) begin
              len[7:0] <= rx_data_i;
              byte_idx <= 2'd1;
            end else begin
              len[15:8] <= rx_data_i;
              byte_idx  <= 2'd0;
            end
          end
        end
        ST_WR_DATA: begin
          if (rx_valid_i) wr_byte <= rx_data_i;
        end
        ST_WR_STB: begin
          addr <= addr + ADDR_ONE;
          len  <= len - 16'd1;
        end
        ST_RD_CAP: begin
          tx_data <= ram_rd_data_i;
        end
        ST_RD_SEND: begin
          if (tx_ready_i) begin
            addr <= addr + ADDR_ONE;
            len  <= len - 16'd1;
            if (len == 16'd1) ram_sel <= 1'b0;
          end
        end
        ST_ACK: begin
          if (tx_ready_i) ram_sel <= 1'b0;
        end
        default: ;
      endcase
      if (load_ack) tx_data <= ack_byte;
    end
  end

  assign rx_ready_o    = rst_n_i & rx_ready_int;
  assign tx_data_o     = tx_data;
  assign ram_rw_sel_o  = ram_sel;
  assign ram_rw_addr_o = addr;
  assign ram_wr_data_o = {{(XLEN-8){1'b0}}, wr_byte};
  assign busy_o        = (state != ST_IDLE);

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus pushes expected strobes/tx bytes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_ram_loader;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b0;
  logic [7:0]      rx_data_i = 8'h00;
  logic            rx_valid_i = 1'b0;
  logic            rx_ready_o;
  logic [7:0]      tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready_i = 1'b1;
  logic            ram_rw_sel_o;
  logic [XLEN-1:0] ram_rw_addr_o;
  logic [XLEN-1:0] ram_wr_data_o;
  logic [3:0]      ram_wr_byte_en_o;
  logic [7:0]      ram_rd_data_i = 8'h00;
  logic            busy_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  logic [7:0] exp_tx[$];
  wr_exp_t    exp_wr[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         sel_must_low = 1'b0;
  bit         check_tput = 1'b0;
  int         last_fire = -1;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] mem [4096];

  ram_loader #(.XLEN(XLEN)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .rx_data_i        (rx_data_i),
    .rx_valid_i       (rx_valid_i),
    .rx_ready_o       (rx_ready_o),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .ram_rw_sel_o     (ram_rw_sel_o),
    .ram_rw_addr_o    (ram_rw_addr_o),
    .ram_wr_data_o    (ram_wr_data_o),
    .ram_wr_byte_en_o (ram_wr_byte_en_o),
    .ram_rd_data_i    (ram_rd_data_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Sparse RAM: the addresses used here are unique in {addr[31:28], addr[7:0]}.
  function automatic logic [11:0] ram_idx(input logic [31:0] a);
    return {a[31:28], a[7:0]};
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  end

  always @(posedge clk_i) begin
    if (ram_wr_byte_en_o[0]) mem[ram_idx(ram_rw_addr_o)] <= ram_wr_data_o[7:0];
    ram_rd_data_i <= mem[ram_idx(ram_rw_addr_o)];
  end

  // Monitor: strobes, tx handshakes, tx hold stability, sel-low window, read throughput.
  initial begin
    wr_exp_t    e;
    logic [7:0] t;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        if (ram_wr_byte_en_o != 4'b0000) begin
          checks++;
          if (exp_wr.size() == 0) begin
            failures++;
            $display("[TB] FAIL wr_unexpected: got addr=%h data=%h en=%b, required no strobe",
                     ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o);
          end else begin
            e = exp_wr.pop_front();
            if (ram_rw_addr_o !== e.addr || ram_wr_data_o !== {24'h0, e.data} ||
                ram_wr_byte_en_o !== 4'b0001) begin
              failures++;
              $display("[TB] FAIL wr_strobe: got addr=%h data=%h en=%b, required addr=%h data=%h en=0001",
                       ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o, e.addr, e.data);
            end
          end
        end
        if (tx_valid_o && tx_ready_i) begin
          checks++;
          if (exp_tx.size() == 0) begin
            failures++;
            $display("[TB] FAIL tx_unexpected: got %h, required no tx byte", tx_data_o);
          end else begin
            t = exp_tx.pop_front();
            if (tx_data_o !== t) begin
              failures++;
              $display("[TB] FAIL tx_byte: got %h, required %h", tx_data_o, t);
            end
          end
          if (check_tput) begin
            if (last_fire >= 0) begin
              checks++;
              if (cyc - last_fire != 3) begin
                failures++;
                $display("[TB] FAIL rd_throughput: got %0d cycles, required 3", cyc - last_fire);
              end
            end
            last_fire = cyc;
          end
        end
        if (prev_valid && !prev_ready) begin
          checks++;
          if (tx_valid_o !== 1'b1 || tx_data_o !== prev_data) begin
            failures++;
            $display("[TB] FAIL tx_hold: got valid=%b data=%h, required valid=1 data=%h",
                     tx_valid_o, tx_data_o, prev_data);
          end
        end
        if (sel_must_low) begin
          checks++;
          if (ram_rw_sel_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nak_sel: got %b, required 0", ram_rw_sel_o);
          end
        end
        prev_valid = tx_valid_o;
        prev_ready = tx_ready_i;
        prev_data  = tx_data_o;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_i);
      ok = rx_ready_o;
      @(posedge clk_i);
      #1;
    end
    rx_valid_i = 1'b0;
    if (!ok) check_output("rx_accept_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  task automatic send_header(input logic [7:0] op, input logic [31:0] a, input logic [15:0] n);
    apply_stimulus(op);
    apply_stimulus(a[7:0]);
    apply_stimulus(a[15:8]);
    apply_stimulus(a[23:16]);
    apply_stimulus(a[31:24]);
    apply_stimulus(n[7:0]);
    apply_stimulus(n[15:8]);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_tx.size() == 0 && exp_wr.size() == 0) break;
      @(posedge clk_i);
      #1;
    end
    check_output(name, 32'(exp_tx.size() + exp_wr.size()), 32'd0);
    exp_tx.delete();
    exp_wr.delete();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_output("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_sel", 32'(ram_rw_sel_o), 32'd0);
    check_output("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_output("rst_tx_data", 32'(tx_data_o), 32'd0);
    check_output("rst_byte_en", 32'(ram_wr_byte_en_o), 32'd0);
    rst_n_i = 1'b1;
    #1;
    check_output("idle_rx_ready", 32'(rx_ready_o), 32'd1);

    // WRITE DE AD BE EF at 0x10000000
    exp_wr.push_back('{32'h1000_0000, 8'hDE});
    exp_wr.push_back('{32'h1000_0001, 8'hAD});
    exp_wr.push_back('{32'h1000_0002, 8'hBE});
    exp_wr.push_back('{32'h1000_0003, 8'hEF});
    exp_tx.push_back(8'h06);
    send_header(8'h01, 32'h1000_0000, 16'd4);
    apply_stimulus(8'hDE);
    apply_stimulus(8'hAD);
    apply_stimulus(8'hBE);
    apply_stimulus(8'hEF);
    wait_drain("write4_drain");
    check_output("write4_idle_sel", 32'(ram_rw_sel_o), 32'd0);

    // READ 0x10000003 N=2 straddles written and unwritten bytes; no ACK follows
    check_tput = 1'b1;
    last_fire  = -1;
    exp_tx.push_back(8'hEF);
    exp_tx.push_back(8'h00);
    send_header(8'h02, 32'h1000_0003, 16'd2);
    wait_drain("read2_drain");
    check_output("read2_busy", 32'(busy_o), 32'd0);

    last_fire = -1;
    exp_tx.push_back(8'hDE);
    exp_tx.push_back(8'hAD);
    exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hEF);
    send_header(8'h02, 32'h1000_0000, 16'd4);
    wait_drain("read4_drain");
    check_tput = 1'b0;

    // Address wrap at the top of the space
    exp_wr.push_back('{32'hFFFF_FFFF, 8'h11});
    exp_wr.push_back('{32'h0000_0000, 8'h22});
    exp_tx.push_back(8'h06);
    send_header(8'h01, 32'hFFFF_FFFF, 16'd2);
    apply_stimulus(8'h11);
    apply_stimulus(8'h22);
    wait_drain("wrap_drain");

    // Unknown opcode
    sel_must_low = 1'b1;
    exp_tx.push_back(8'h15);
    apply_stimulus(8'h7F);
    wait_drain("nak_drain");
    sel_must_low = 1'b0;
    check_output("nak_busy", 32'(busy_o), 32'd0);

    // Zero-length WRITE: ACK only
    exp_tx.push_back(8'h06);
    send_header(8'h01, 32'h0000_0040, 16'd0);
    wait_drain("zero_len_drain");

    // READ with the host stalling for more than ten cycles
    tx_ready_i = 1'b0;
    exp_tx.push_back(8'hAD);
    send_header(8'h02, 32'h1000_0001, 16'd1);
    repeat (12) @(posedge clk_i);
    #1;
    check_output("stall_valid", 32'(tx_valid_o), 32'd1);
    check_output("stall_data", 32'(tx_data_o), 32'hAD);
    tx_ready_i = 1'b1;
    wait_drain("stall_drain");

    // Reset mid-WRITE after two data bytes
    exp_wr.push_back('{32'h0000_0020, 8'hAA});
    exp_wr.push_back('{32'h0000_0021, 8'hBB});
    send_header(8'h01, 32'h0000_0020, 16'd4);
    apply_stimulus(8'hAA);
    apply_stimulus(8'hBB);
    @(posedge clk_i);
    #3;
    check_output("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_output("mid_rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check_output("mid_rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check_output("mid_rst_tx_data", 32'(tx_data_o), 32'd0);
    check_output("mid_rst_sel", 32'(ram_rw_sel_o), 32'd0);
    check_output("mid_rst_addr", ram_rw_addr_o, 32'd0);
    check_output("mid_rst_wr_data", ram_wr_data_o, 32'd0);
    check_output("mid_rst_byte_en", 32'(ram_wr_byte_en_o), 32'd0);
    check_output("mid_rst_busy", 32'(busy_o), 32'd0);
    check_output("mid_rst_strobes_seen", 32'(exp_wr.size()), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    #1;

    exp_tx.push_back(8'hAA);
    exp_tx.push_back(8'hBB);
    send_header(8'h02, 32'h0000_0020, 16'd2);
    wait_drain("post_rst_read_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
